// File: rtl/rect_fill_fsm.sv
// rtl/rect_fill_fsm.sv - solid rectangle fill (optional full-screen clear) pixel generator
module rect_fill_fsm #(
    parameter int         SCREEN_W    = 160,
    parameter int         SCREEN_H    = 120,
    parameter logic [2:0] CLEAR_COLOR = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       clear_first,
    input  logic [8:0] x0,
    input  logic [8:0] y0,
    input  logic [8:0] x1,
    input  logic [8:0] y1,
    input  logic [2:0] input_color,
    output logic [8:0] x_out,
    output logic [8:0] y_out,
    output logic       write_out,
    output logic [2:0] color,
    output logic       busy,
    output logic       done
);

    localparam logic [8:0] X_LAST = 9'(SCREEN_W - 1);
    localparam logic [8:0] Y_LAST = 9'(SCREEN_H - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, FILL, DONE} state_t;

    state_t     state, state_n;
    logic [8:0] xmin, xmax, ymin, ymax;
    logic [8:0] xmin_n, xmax_n, ymin_n, ymax_n;
    logic [2:0] fill_color, fill_color_n;
    logic [8:0] cx, cy, cx_n, cy_n;
    logic [8:0] x_out_n, y_out_n;
    logic [2:0] color_n;
    logic       write_n, busy_n, done_n;
    logic [8:0] lo_x, hi_x, lo_y, hi_y;

    function automatic logic [8:0] sat(input logic [8:0] v, input logic [8:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    always_comb begin
        lo_x = (x0 < x1) ? x0 : x1;
        hi_x = (x0 < x1) ? x1 : x0;
        lo_y = (y0 < y1) ? y0 : y1;
        hi_y = (y0 < y1) ? y1 : y0;
    end

    // Outputs are computed here and registered, so each pixel appears one edge after the cursor reaches it.
    always_comb begin
        state_n      = state;
        xmin_n       = xmin;
        xmax_n       = xmax;
        ymin_n       = ymin;
        ymax_n       = ymax;
        fill_color_n = fill_color;
        cx_n         = cx;
        cy_n         = cy;
        x_out_n      = x_out;
        y_out_n      = y_out;
        color_n      = color;
        write_n      = 1'b0;
        busy_n       = 1'b0;
        done_n       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    xmin_n       = sat(lo_x, X_LAST);
                    xmax_n       = sat(hi_x, X_LAST);
                    ymin_n       = sat(lo_y, Y_LAST);
                    ymax_n       = sat(hi_y, Y_LAST);
                    fill_color_n = input_color;
                    if (clear_first) begin
                        state_n = CLEAR;
                        cx_n    = '0;
                        cy_n    = '0;
                    end else begin
                        state_n = FILL;
                        cx_n    = xmin_n;
                        cy_n    = ymin_n;
                    end
                end
            end
            CLEAR: begin
                x_out_n = cx;
                y_out_n = cy;
                color_n = CLEAR_COLOR;
                write_n = 1'b1;
                busy_n  = 1'b1;
                if (cx != X_LAST) begin
                    cx_n = cx + 9'd1;
                end else if (cy != Y_LAST) begin
                    cx_n = '0;
                    cy_n = cy + 9'd1;
                end else begin
                    // Hand straight over to the fill so there is no idle cycle between passes.
                    state_n = FILL;
                    cx_n    = xmin;
                    cy_n    = ymin;
                end
            end
            FILL: begin
                x_out_n = cx;
                y_out_n = cy;
                color_n = fill_color;
                write_n = 1'b1;
                busy_n  = 1'b1;
                if (cx != xmax) begin
                    cx_n = cx + 9'd1;
                end else if (cy != ymax) begin
                    cx_n = xmin;
                    cy_n = cy + 9'd1;
                end else begin
                    state_n = DONE;
                end
            end
            DONE: begin
                done_n  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            xmin       <= '0;
            xmax       <= '0;
            ymin       <= '0;
            ymax       <= '0;
            fill_color <= '0;
            cx         <= '0;
            cy         <= '0;
            x_out      <= '0;
            y_out      <= '0;
            color      <= '0;
            write_out  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            xmin       <= xmin_n;
            xmax       <= xmax_n;
            ymin       <= ymin_n;
            ymax       <= ymax_n;
            fill_color <= fill_color_n;
            cx         <= cx_n;
            cy         <= cy_n;
            x_out      <= x_out_n;
            y_out      <= y_out_n;
            color      <= color_n;
            write_out  <= write_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

endmodule

// File: tb/tb_rect_fill_fsm.sv
// tb/tb_rect_fill_fsm.sv - randomized self-checking bench for rect_fill_fsm
module tb_rect_fill_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       clear_first;
    logic [8:0] x0, y0, x1, y1;
    logic [2:0] input_color;
    logic [8:0] x_out, y_out;
    logic       write_out;
    logic [2:0] color;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rect_fill_fsm dut (
        .clk(clk), .reset(reset), .start(start), .clear_first(clear_first),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .input_color(input_color),
        .x_out(x_out), .y_out(y_out), .write_out(write_out), .color(color),
        .busy(busy), .done(done)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int pack(input int x, input int y, input int c);
        return (x << 12) | (y << 3) | c;
    endfunction

    function automatic int clip(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic scramble_inputs();
        x0          = 9'($urandom);
        y0          = 9'($urandom);
        x1          = 9'($urandom);
        y1          = 9'($urandom);
        input_color = 3'($urandom);
        clear_first = 1'($urandom);
    endtask

    // Issues one request and checks pixel order, timing, busy and the done pulse against a list built from the rules.
    task automatic run_req(input bit clr, input int ax, input int ay, input int bx, input int by,
                           input int col, input bit extra);
        int exp_q[$];
        int xl, xh, yl, yh;
        int cyc, nw, first, last, donec, done_at, busyc, limit;
        xl = clip((ax < bx) ? ax : bx, 159);
        xh = clip((ax < bx) ? bx : ax, 159);
        yl = clip((ay < by) ? ay : by, 119);
        yh = clip((ay < by) ? by : ay, 119);
        if (clr)
            for (int y = 0; y < 120; y++)
                for (int x = 0; x < 160; x++)
                    exp_q.push_back(pack(x, y, 0));
        for (int y = yl; y <= yh; y++)
            for (int x = xl; x <= xh; x++)
                exp_q.push_back(pack(x, y, col));

        @(negedge clk);
        start       = 1'b1;
        clear_first = clr;
        x0 = 9'(ax); y0 = 9'(ay); x1 = 9'(bx); y1 = 9'(by);
        input_color = 3'(col);
        cyc = 0; nw = 0; first = -1; last = -1; donec = 0; done_at = -1; busyc = 0;
        limit = exp_q.size() + 30;
        while (cyc < limit && !(done_at >= 0 && cyc > done_at + 2)) begin
            @(negedge clk);
            cyc++;
            if (write_out) begin
                if (nw < exp_q.size())
                    check("pixel", pack(int'(x_out), int'(y_out), int'(color)), exp_q[nw]);
                if (first < 0) first = cyc;
                last = cyc;
                nw++;
            end
            if (busy) busyc++;
            if (done) begin
                donec++;
                done_at = cyc;
            end
            scramble_inputs();
            start = (extra && cyc == 3 && exp_q.size() >= 4);
        end
        start = 1'b0;
        check("write_count", nw, exp_q.size());
        check("first_write_latency", first, 2);
        check("no_gaps", last - first + 1, exp_q.size());
        check("done_after_last", done_at, last + 1);
        check("done_pulses", donec, 1);
        check("busy_cycles", busyc, exp_q.size());
        check("idle_write", int'(write_out), 0);
    endtask

    initial begin
        int nw;
        int ax, ay, bx, by;
        reset = 1'b0; start = 1'b1; clear_first = 1'b0;
        x0 = 9'd5; y0 = 9'd5; x1 = 9'd9; y1 = 9'd9; input_color = 3'b111;

        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_outputs", int'({x_out, y_out, color, write_out, busy, done}), 0);
        end
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_idle", int'({write_out, busy, done}), 0);
        end

        run_req(0, 3, 4, 4, 5, 5, 0);
        run_req(0, 200, 130, 158, 118, 3, 0);
        run_req(0, 2, 2, 6, 4, 3, 1);
        run_req(0, 7, 9, 7, 9, 1, 0);
        run_req(0, 300, 20, 511, 22, 6, 0);
        run_req(1, 10, 10, 10, 10, 2, 0);

        for (int k = 0; k < 10; k++) begin
            ax = (k % 3 == 0) ? int'($urandom_range(150, 511)) : int'($urandom_range(0, 159));
            ay = (k % 4 == 0) ? int'($urandom_range(110, 511)) : int'($urandom_range(0, 119));
            bx = ax + int'($urandom_range(0, 16)) - 8;
            by = ay + int'($urandom_range(0, 12)) - 6;
            if (bx < 0) bx = 0;
            if (by < 0) by = 0;
            if (bx > 511) bx = 511;
            if (by > 511) by = 511;
            run_req(0, ax, ay, bx, by, int'($urandom_range(0, 7)), 1'($urandom));
        end

        @(negedge clk);
        start = 1'b1; clear_first = 1'b0;
        x0 = 9'd20; y0 = 9'd30; x1 = 9'd29; y1 = 9'd39; input_color = 3'b110;
        nw = 0;
        for (int i = 0; i < 40 && nw < 5; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (write_out) nw++;
        end
        check("mid_reset_5th_write", nw, 5);
        reset = 1'b0;
        @(negedge clk);
        check("mid_reset_outputs", int'({write_out, busy, done}), 0);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("after_abort_quiet", int'({write_out, busy, done}), 0);
        end
        run_req(0, 20, 30, 29, 39, 6, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
